// File: rtl/decoder4_16_seq_if.sv
// Request/response bundle for the registered 4-to-16 decoder.
// The master (requester) drives the I_* signals and the slave (decoder) drives the O_* signals.
interface decoder4_16_seq_if;
   // A request is taken on a rising edge where O_READY and (I_VALID or I_SWEEP) are both high.
   // I_DATA is sampled only at that edge. O_READY never depends on I_VALID or I_SWEEP.
   logic [3:0]  I_DATA;
   logic        I_VALID;
   logic        I_SWEEP;
   logic        O_READY;
   logic [15:0] O_DATA;
   logic [3:0]  O_INDEX;
   logic        O_VALID;
   logic        O_DONE;

   modport master (
      output I_DATA, I_VALID, I_SWEEP,
      input  O_READY, O_DATA, O_INDEX, O_VALID, O_DONE
   );

   modport slave (
      input  I_DATA, I_VALID, I_SWEEP,
      output O_READY, O_DATA, O_INDEX, O_VALID, O_DONE
   );
endinterface

// File: rtl/decoder4_16_seq.sv
// Registered 4-to-16 one-hot decoder with a programmable pulse width and valid/ready request.
// Define DECODER4_16_SWEEP_EN to build the sweep mode that walks all 16 outputs in order.
module decoder4_16_seq #(
   parameter int PULSE_CYCLES = 1
) (
   input  logic                     I_CLK,
   input  logic                     I_NRESET,
   input  logic                     I_ENABLE,
   decoder4_16_seq_if.slave         bus,
   output logic [1:0]               dbg_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      SWEEP  = 2'd2
   } state_t;

   localparam logic [7:0] LAST = 8'(PULSE_CYCLES - 1);

   state_t     state;
   logic [7:0] cnt;
   logic       last;
   logic       accept_sweep;
   logic       accept_dec;

   assign last        = (cnt == LAST);
   assign bus.O_READY = I_ENABLE & ((state == IDLE) | ((state == DECODE) & last));
   assign dbg_state   = state;

`ifdef DECODER4_16_SWEEP_EN
   assign accept_sweep = bus.O_READY & bus.I_SWEEP;
`else
   logic unused_sweep;
   assign unused_sweep = bus.I_SWEEP;
   assign accept_sweep = 1'b0;
   assign bus.O_DONE   = 1'b0;
`endif

   // Sweep wins over a decode request arriving in the same cycle.
   assign accept_dec = bus.O_READY & bus.I_VALID & ~accept_sweep;

   always_ff @(posedge I_CLK or negedge I_NRESET) begin
      if (!I_NRESET) begin
         state       <= IDLE;
         cnt         <= 8'd0;
         bus.O_DATA  <= 16'h0000;
         bus.O_INDEX <= 4'd0;
         bus.O_VALID <= 1'b0;
`ifdef DECODER4_16_SWEEP_EN
         bus.O_DONE  <= 1'b0;
`endif
      end else if (!I_ENABLE) begin
         state       <= IDLE;
         cnt         <= 8'd0;
         bus.O_DATA  <= 16'h0000;
         bus.O_INDEX <= 4'd0;
         bus.O_VALID <= 1'b0;
`ifdef DECODER4_16_SWEEP_EN
         bus.O_DONE  <= 1'b0;
`endif
      end else if (accept_sweep) begin
         state       <= SWEEP;
         cnt         <= 8'd0;
         bus.O_DATA  <= 16'h0001;
         bus.O_INDEX <= 4'd0;
         bus.O_VALID <= 1'b1;
      end else if (accept_dec) begin
         state       <= DECODE;
         cnt         <= 8'd0;
         bus.O_DATA  <= 16'h0001 << bus.I_DATA;
         bus.O_INDEX <= bus.I_DATA;
         bus.O_VALID <= 1'b1;
      end else begin
         case (state)
            DECODE: begin
               if (last) begin
                  state       <= IDLE;
                  cnt         <= 8'd0;
                  bus.O_DATA  <= 16'h0000;
                  bus.O_INDEX <= 4'd0;
                  bus.O_VALID <= 1'b0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
`ifdef DECODER4_16_SWEEP_EN
            // O_DONE is registered, so it is set on the edge entering the final cycle of index 15.
            SWEEP: begin
               if (last) begin
                  cnt <= 8'd0;
                  if (bus.O_INDEX == 4'd15) begin
                     state       <= IDLE;
                     bus.O_DATA  <= 16'h0000;
                     bus.O_INDEX <= 4'd0;
                     bus.O_VALID <= 1'b0;
                     bus.O_DONE  <= 1'b0;
                  end else begin
                     bus.O_DATA  <= bus.O_DATA << 1;
                     bus.O_INDEX <= bus.O_INDEX + 4'd1;
                     bus.O_DONE  <= (LAST == 8'd0) && (bus.O_INDEX == 4'd14);
                  end
               end else begin
                  cnt        <= cnt + 8'd1;
                  bus.O_DONE <= (bus.O_INDEX == 4'd15) && ((cnt + 8'd1) == LAST);
               end
            end
`endif
            default: begin
               state       <= IDLE;
               cnt         <= 8'd0;
               bus.O_DATA  <= 16'h0000;
               bus.O_INDEX <= 4'd0;
               bus.O_VALID <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_decoder4_16_seq.sv
// Directed bench for decoder4_16_seq using three instances with pulse widths 1, 2 and 3.
// Sweep scenarios follow DECODER4_16_SWEEP_EN; otherwise the bench checks that I_SWEEP is ignored.
module tb_decoder4_16_seq;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic [1:0] st1, st2, st3;
   int         tests_run;
   int         tests_failed;

   decoder4_16_seq_if if1 ();
   decoder4_16_seq_if if2 ();
   decoder4_16_seq_if if3 ();

   decoder4_16_seq #(.PULSE_CYCLES(1)) dut1 (
      .I_CLK(clk), .I_NRESET(rst_n), .I_ENABLE(enable), .bus(if1), .dbg_state(st1));
   decoder4_16_seq #(.PULSE_CYCLES(2)) dut2 (
      .I_CLK(clk), .I_NRESET(rst_n), .I_ENABLE(enable), .bus(if2), .dbg_state(st2));
   decoder4_16_seq #(.PULSE_CYCLES(3)) dut3 (
      .I_CLK(clk), .I_NRESET(rst_n), .I_ENABLE(enable), .bus(if3), .dbg_state(st3));

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      enable = 1'b1;
      if1.I_DATA = 4'd0; if1.I_VALID = 1'b0; if1.I_SWEEP = 1'b0;
      if2.I_DATA = 4'd0; if2.I_VALID = 1'b0; if2.I_SWEEP = 1'b0;
      if3.I_DATA = 4'd0; if3.I_VALID = 1'b0; if3.I_SWEEP = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      tests_run++;
      if (if1.O_DATA !== 16'h0000) begin tests_failed++; $display("FAIL reset_data got %h want 0000", if1.O_DATA); end
      tests_run++;
      if (if1.O_INDEX !== 4'd0) begin tests_failed++; $display("FAIL reset_index got %0d want 0", if1.O_INDEX); end
      tests_run++;
      if (if1.O_VALID !== 1'b0 || if1.O_DONE !== 1'b0) begin
         tests_failed++; $display("FAIL reset_valid_done got %b%b want 00", if1.O_VALID, if1.O_DONE);
      end
      tests_run++;
      if (if3.O_READY !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %b want 1", if3.O_READY); end
   endtask

   task automatic test_single_decode();
      if1.I_DATA = 4'd5; if1.I_VALID = 1'b1;
      tick();
      if1.I_VALID = 1'b0; if1.I_DATA = 4'd12;
      tests_run++;
      if (if1.O_DATA !== 16'h0020 || if1.O_INDEX !== 4'd5 || if1.O_VALID !== 1'b1) begin
         tests_failed++;
         $display("FAIL decode5 got data=%h idx=%0d v=%b want 0020 5 1", if1.O_DATA, if1.O_INDEX, if1.O_VALID);
      end
      tick();
      tests_run++;
      if (if1.O_DATA !== 16'h0000 || if1.O_VALID !== 1'b0 || if1.O_INDEX !== 4'd0) begin
         tests_failed++;
         $display("FAIL decode5_end got data=%h idx=%0d v=%b want 0000 0 0", if1.O_DATA, if1.O_INDEX, if1.O_VALID);
      end
   endtask

   task automatic test_vector_table();
      logic [3:0]  idx_tab [4] = '{4'd0, 4'd1, 4'd10, 4'd14};
      logic [15:0] exp_tab [4] = '{16'h0001, 16'h0002, 16'h0400, 16'h4000};
      // Pulse width 1 keeps O_READY high, so these go out back to back.
      for (int i = 0; i < 4; i++) begin
         if1.I_DATA = idx_tab[i]; if1.I_VALID = 1'b1;
         tick();
         tests_run++;
         if (if1.O_DATA !== exp_tab[i] || if1.O_INDEX !== idx_tab[i] || if1.O_VALID !== 1'b1) begin
            tests_failed++;
            $display("FAIL table[%0d] got data=%h idx=%0d v=%b want %h %0d 1",
                     i, if1.O_DATA, if1.O_INDEX, if1.O_VALID, exp_tab[i], idx_tab[i]);
         end
      end
      if1.I_VALID = 1'b0;
      tick();
      tests_run++;
      if (if1.O_VALID !== 1'b0) begin tests_failed++; $display("FAIL table_end got v=%b want 0", if1.O_VALID); end
   endtask

   task automatic test_pulse_width();
      if3.I_DATA = 4'd15; if3.I_VALID = 1'b1;
      tick();
      if3.I_VALID = 1'b0; if3.I_DATA = 4'd2;
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if (if3.O_DATA !== 16'h8000 || if3.O_INDEX !== 4'd15 || if3.O_VALID !== 1'b1 || if3.O_READY !== (i == 2)) begin
            tests_failed++;
            $display("FAIL pulse3[%0d] got data=%h idx=%0d v=%b rdy=%b want 8000 15 1 %b",
                     i, if3.O_DATA, if3.O_INDEX, if3.O_VALID, if3.O_READY, (i == 2));
         end
         tick();
      end
      tests_run++;
      if (if3.O_DATA !== 16'h0000 || if3.O_VALID !== 1'b0 || if3.O_READY !== 1'b1) begin
         tests_failed++;
         $display("FAIL pulse3_end got data=%h v=%b rdy=%b want 0000 0 1", if3.O_DATA, if3.O_VALID, if3.O_READY);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_d [4] = '{16'h0001, 16'h0001, 16'h0200, 16'h0200};
      logic        exp_r [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      if2.I_DATA = 4'd0; if2.I_VALID = 1'b1;
      tick();
      if2.I_VALID = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (if2.O_DATA !== exp_d[i] || if2.O_VALID !== 1'b1 || if2.O_READY !== exp_r[i]) begin
            tests_failed++;
            $display("FAIL b2b[%0d] got data=%h v=%b rdy=%b want %h 1 %b",
                     i, if2.O_DATA, if2.O_VALID, if2.O_READY, exp_d[i], exp_r[i]);
         end
         if (i == 1) begin if2.I_DATA = 4'd9; if2.I_VALID = 1'b1; end
         tick();
         if2.I_VALID = 1'b0;
      end
      tests_run++;
      if (if2.O_DATA !== 16'h0000 || if2.O_VALID !== 1'b0) begin
         tests_failed++; $display("FAIL b2b_end got data=%h v=%b want 0000 0", if2.O_DATA, if2.O_VALID);
      end
   endtask

`ifdef DECODER4_16_SWEEP_EN
   task automatic test_sweep();
      logic [15:0] exp_d;
      if1.I_SWEEP = 1'b1; if1.I_VALID = 1'b1; if1.I_DATA = 4'd7;
      tick();
      if1.I_SWEEP = 1'b0; if1.I_VALID = 1'b0;
      exp_d = 16'h0001;
      for (int i = 0; i < 16; i++) begin
         tests_run++;
         if (if1.O_DATA !== exp_d || if1.O_INDEX !== 4'(i) || if1.O_VALID !== 1'b1 ||
             if1.O_DONE !== (i == 15) || if1.O_READY !== 1'b0) begin
            tests_failed++;
            $display("FAIL sweep[%0d] got data=%h idx=%0d v=%b done=%b rdy=%b want %h %0d 1 %b 0",
                     i, if1.O_DATA, if1.O_INDEX, if1.O_VALID, if1.O_DONE, if1.O_READY, exp_d, i, (i == 15));
         end
         exp_d = {exp_d[14:0], 1'b0};
         tick();
      end
      tests_run++;
      if (if1.O_DATA !== 16'h0000 || if1.O_VALID !== 1'b0 || if1.O_DONE !== 1'b0 || if1.O_READY !== 1'b1) begin
         tests_failed++;
         $display("FAIL sweep_end got data=%h v=%b done=%b rdy=%b want 0000 0 0 1",
                  if1.O_DATA, if1.O_VALID, if1.O_DONE, if1.O_READY);
      end
   endtask

   task automatic test_sweep_abort();
      if1.I_SWEEP = 1'b1;
      tick();
      if1.I_SWEEP = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tests_run++;
         if (if1.O_DONE !== 1'b0) begin tests_failed++; $display("FAIL abort_done[%0d] got 1 want 0", i); end
         tick();
      end
      tests_run++;
      if (if1.O_INDEX !== 4'd6 || if1.O_DATA !== 16'h0040) begin
         tests_failed++; $display("FAIL abort_at6 got idx=%0d data=%h want 6 0040", if1.O_INDEX, if1.O_DATA);
      end
      enable = 1'b0;
      #1;
      tests_run++;
      if (if1.O_READY !== 1'b0) begin tests_failed++; $display("FAIL abort_ready got %b want 0", if1.O_READY); end
      tick();
      enable = 1'b1;
      tests_run++;
      if (if1.O_DATA !== 16'h0000 || if1.O_VALID !== 1'b0 || if1.O_INDEX !== 4'd0 || if1.O_DONE !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort got data=%h v=%b idx=%0d done=%b want 0000 0 0 0",
                  if1.O_DATA, if1.O_VALID, if1.O_INDEX, if1.O_DONE);
      end
      tick();
      tests_run++;
      if (if1.O_DONE !== 1'b0 || if1.O_VALID !== 1'b0) begin
         tests_failed++; $display("FAIL abort_after got done=%b v=%b want 0 0", if1.O_DONE, if1.O_VALID);
      end
   endtask
`else
   task automatic test_sweep_ignored();
      if1.I_SWEEP = 1'b1;
      tick();
      tests_run++;
      if (if1.O_VALID !== 1'b0 || if1.O_DONE !== 1'b0 || if1.O_DATA !== 16'h0000) begin
         tests_failed++;
         $display("FAIL sweep_ignored got data=%h v=%b done=%b want 0000 0 0", if1.O_DATA, if1.O_VALID, if1.O_DONE);
      end
      if1.I_VALID = 1'b1; if1.I_DATA = 4'd7;
      tick();
      if1.I_SWEEP = 1'b0; if1.I_VALID = 1'b0;
      tests_run++;
      if (if1.O_DATA !== 16'h0080 || if1.O_INDEX !== 4'd7 || if1.O_DONE !== 1'b0) begin
         tests_failed++;
         $display("FAIL sweep_nodone got data=%h idx=%0d done=%b want 0080 7 0", if1.O_DATA, if1.O_INDEX, if1.O_DONE);
      end
      tick();
   endtask
`endif

   task automatic test_async_reset();
      if3.I_DATA = 4'd3; if3.I_VALID = 1'b1;
      tick();
      if3.I_VALID = 1'b0;
      tests_run++;
      if (if3.O_DATA !== 16'h0008) begin tests_failed++; $display("FAIL areset_pre got %h want 0008", if3.O_DATA); end
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (if3.O_DATA !== 16'h0000 || if3.O_VALID !== 1'b0 || if3.O_INDEX !== 4'd0) begin
         tests_failed++;
         $display("FAIL areset got data=%h v=%b idx=%0d want 0000 0 0", if3.O_DATA, if3.O_VALID, if3.O_INDEX);
      end
      #2;
      rst_n = 1'b1;
      tick();
      tests_run++;
      if (if3.O_VALID !== 1'b0 || if3.O_READY !== 1'b1) begin
         tests_failed++; $display("FAIL areset_after got v=%b rdy=%b want 0 1", if3.O_VALID, if3.O_READY);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_single_decode();
      test_vector_table();
      test_pulse_width();
      test_back_to_back();
`ifdef DECODER4_16_SWEEP_EN
      test_sweep();
      test_sweep_abort();
`else
      test_sweep_ignored();
`endif
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
